// File: rtl/bsg_chip_pkg.sv
// Shared constants and the divider FSM state type.
package bsg_chip_pkg;

  localparam int unsigned width_default_p = 32;

  typedef enum logic [1:0] {
    eIdle = 2'd0,
    eBusy = 2'd1,
    eDone = 2'd2
  } idiv_state_e;

endpackage

// File: rtl/bsg_idiv_seq_if.sv
// Request/result bundle of the sequential divider.
interface bsg_idiv_seq_if
  import bsg_chip_pkg::*;
#(parameter int unsigned width_p = width_default_p);

  logic                   v_i;
  logic                   ready_o;
  logic [2*width_p-1:0]   dividend_i;
  logic [width_p-1:0]     divisor_i;
  logic                   v_o;
  logic                   yumi_i;
  logic [width_p-1:0]     quotient_o;
  logic [width_p-1:0]     remainder_o;
  logic                   error_o;

  modport master (
    output v_i, dividend_i, divisor_i, yumi_i,
    input  ready_o, v_o, quotient_o, remainder_o, error_o
  );

  modport slave (
    input  v_i, dividend_i, divisor_i, yumi_i,
    output ready_o, v_o, quotient_o, remainder_o, error_o
  );

endinterface

// File: rtl/bsg_idiv_step.sv
// One radix-2 restoring division step: shift in a dividend bit, conditionally subtract.
module bsg_idiv_step
  import bsg_chip_pkg::*;
#(parameter int unsigned width_p = width_default_p)
(
  input  logic [width_p-1:0] rem_i,
  input  logic               bit_i,
  input  logic [width_p-1:0] divisor_i,
  output logic [width_p-1:0] rem_o,
  output logic               q_bit_o
);

  logic [width_p:0]   shifted;
  logic [width_p-1:0] diff;

  assign shifted = {rem_i, bit_i};
  assign q_bit_o = (shifted >= {1'b0, divisor_i});
  // The true difference is below the divisor, so the low width_p bits suffice.
  assign diff    = shifted[width_p-1:0] - divisor_i;
  assign rem_o   = q_bit_o ? diff : shifted[width_p-1:0];

endmodule

// File: rtl/bsg_idiv_seq.sv
// Sequential unsigned 2N/N divider; one restoring step per cycle, error on /0 or overflow.
module bsg_idiv_seq
  import bsg_chip_pkg::*;
#(parameter int unsigned width_p = width_default_p)
(
  input  logic           clk_i,
  input  logic           reset_i,
  bsg_idiv_seq_if.slave  io
);

  localparam int unsigned cnt_w_lp = $clog2(width_p + 1);
  localparam logic [cnt_w_lp-1:0] last_cnt_lp = cnt_w_lp'(width_p - 1);

  idiv_state_e         state_q, state_d;
  logic [cnt_w_lp-1:0] cnt_q, cnt_d;
  logic [width_p-1:0]  rem_q, rem_d;
  logic [width_p-1:0]  quot_q, quot_d;
  logic [width_p-1:0]  div_q, div_d;
  logic                err_q, err_d;

  logic [width_p-1:0]  step_rem;
  logic                step_qbit;

  // quot_q starts as the dividend low half and is shifted out MSB first while quotient bits enter at the LSB.
  bsg_idiv_step #(.width_p(width_p)) step (
    .rem_i     (rem_q),
    .bit_i     (quot_q[width_p-1]),
    .divisor_i (div_q),
    .rem_o     (step_rem),
    .q_bit_o   (step_qbit)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quot_d  = quot_q;
    div_d   = div_q;
    err_d   = err_q;
    unique case (state_q)
      eIdle: begin
        if (io.v_i) begin
          div_d  = io.divisor_i;
          quot_d = io.dividend_i[width_p-1:0];
          rem_d  = io.dividend_i[2*width_p-1:width_p];
          cnt_d  = '0;
          err_d  = 1'b0;
          if (io.divisor_i == '0) begin
            state_d = eDone;
            err_d   = 1'b1;
            quot_d  = '1;
            rem_d   = io.dividend_i[width_p-1:0];
          end else if (io.dividend_i[2*width_p-1:width_p] >= io.divisor_i) begin
            state_d = eDone;
            err_d   = 1'b1;
            quot_d  = '1;
            rem_d   = '0;
          end else begin
            state_d = eBusy;
          end
        end
      end
      eBusy: begin
        rem_d  = step_rem;
        quot_d = (quot_q << 1) | width_p'(step_qbit);
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == last_cnt_lp) state_d = eDone;
      end
      eDone: begin
        if (io.yumi_i) begin
          state_d = eIdle;
          err_d   = 1'b0;
        end
      end
      default: state_d = eIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= eIdle;
      cnt_q   <= '0;
      rem_q   <= '0;
      quot_q  <= '0;
      div_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quot_q  <= quot_d;
      div_q   <= div_d;
      err_q   <= err_d;
    end
  end

  assign io.ready_o     = (state_q == eIdle);
  assign io.v_o         = (state_q == eDone);
  assign io.quotient_o  = io.v_o ? quot_q : '0;
  assign io.remainder_o = io.v_o ? rem_q  : '0;
  assign io.error_o     = io.v_o & err_q;

endmodule
